march_bist_engine: RTL and testbench

Parametrised March C- memory BIST engine that drives an external synchronous single-port RAM through its own memory port. It runs the full algorithm over every address for a configurable set of data backgrounds and compares read data in a one-stage pipeline. It logs the first failure and a saturating failure count, and reports done/pass. The integrator muxes its memory port against functional traffic using bist_busy.

---
 rtl/march_bist_pkg.sv | 48 ++++
 rtl/march_addr_gen.sv | 38 +++
 rtl/march_bist_engine.sv | 176 +++++++++++++++++
 tb/tb_march_bist_engine.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/march_bist_pkg.sv
// Shared types and March C- element tables for the memory BIST engine.
// Tables are bit-masks indexed by element number (bit 0 = M0).
package march_bist_pkg;

  localparam int MAX_DW = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    EL_M0 = 3'd0,
    EL_M1 = 3'd1,
    EL_M2 = 3'd2,
    EL_M3 = 3'd3,
    EL_M4 = 3'd4,
    EL_M5 = 3'd5
  } elem_t;

  // 1 = element walks addresses N-1..0
  localparam logic [5:0] EL_DOWN     = 6'b111000;
  localparam logic [5:0] EL_FIRST_RD = 6'b111110;
  // 1 = read expects ~D
  localparam logic [5:0] EL_RD_INV   = 6'b010100;
  localparam logic [5:0] EL_HAS_WR   = 6'b011111;
  // 1 = write stores ~D
  localparam logic [5:0] EL_WR_INV   = 6'b001010;

  function automatic logic el_flag(input logic [5:0] tbl, input elem_t e);
    logic f;
    f = 1'b0;
    for (int i = 0; i < 6; i++)
      if (int'(e) == i) f = tbl[i];
    return f;
  endfunction

  function automatic logic [MAX_DW-1:0] bg_pattern(input int b, input int dw);
    logic [MAX_DW-1:0] p;
    p = '0;
    for (int i = 0; i < MAX_DW; i++)
      if (b >= 1 && i < dw) p[i] = ((i >> (b - 1)) & 1) != 0;
    return p;
  endfunction

endpackage

// File: rtl/march_addr_gen.sv
// Up/down address counter for one March element; reloads for the next
// element's direction on the last address instead of wrapping.
module march_addr_gen #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clear,
  input  logic              i_step,
  input  logic              i_down,
  input  logic              i_next_down,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_last
);

  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

  logic [ADDR_W-1:0] r_addr;

  assign o_addr = r_addr;
  assign o_last = i_down ? (r_addr == '0) : (r_addr == ADDR_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr <= '0;
    end else if (i_clear) begin
      r_addr <= '0;
    end else if (i_step) begin
      if (o_last)
        r_addr <= i_next_down ? ADDR_MAX : '0;
      else if (i_down)
        r_addr <= r_addr - 1'b1;
      else
        r_addr <= r_addr + 1'b1;
    end
  end

endmodule

// File: rtl/march_bist_engine.sv
// March C- BIST engine: drives a synchronous single-port RAM, compares
// read data one cycle later, logs first failure and a saturating count.
module march_bist_engine
  import march_bist_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8,
  parameter int NUM_BG = 1,
  parameter int CNT_W  = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          abort,
  input  logic                          stop_on_fail,
  output logic                          mem_cs,
  output logic                          mem_we,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [DATA_W-1:0]             mem_wdata,
  input  logic [DATA_W-1:0]             mem_rdata,
  output logic                          bist_busy,
  output logic                          done,
  output logic                          pass,
  output logic [CNT_W-1:0]              fail_cnt,
  output logic                          fail_valid,
  output logic [ADDR_W-1:0]             fail_addr,
  output logic [2:0]                    fail_elem,
  output logic [$clog2(NUM_BG+1)-1:0]   fail_bg,
  output logic [DATA_W-1:0]             fail_syndrome
);

  localparam int BG_W = $clog2(NUM_BG + 1);
  localparam logic [BG_W-1:0]  BG_LAST = BG_W'(NUM_BG - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t              r_state, w_state_next;
  elem_t               r_elem, w_elem_next, r_cmp_elem, r_fail_elem;
  logic                r_phase, r_stop_on_fail, r_done, r_fail_valid, r_cmp_valid;
  logic [BG_W-1:0]     r_bg, r_cmp_bg, r_fail_bg;
  logic [CNT_W-1:0]    r_fail_cnt;
  logic [ADDR_W-1:0]   r_cmp_addr, r_fail_addr, w_addr;
  logic [DATA_W-1:0]   r_exp, r_fail_syn;
  logic [DATA_W-1:0]   w_pat, w_exp, w_wdata, w_rd_diff;
  logic                w_run, w_active, w_accept, w_rw_elem, w_op_rd, w_addr_done;
  logic                w_step, w_addr_last, w_test_last, w_mismatch, w_to_done;

  assign w_pat       = DATA_W'(bg_pattern(int'(r_bg), DATA_W));
  assign w_run       = (r_state == ST_RUN);
  assign w_active    = w_run || (r_state == ST_DRAIN);
  assign w_accept    = start && !abort && (r_state == ST_IDLE || r_state == ST_DONE);
  assign w_rw_elem   = el_flag(EL_FIRST_RD, r_elem) && el_flag(EL_HAS_WR, r_elem);
  assign w_op_rd     = el_flag(EL_FIRST_RD, r_elem) && !r_phase;
  assign w_addr_done = r_phase || !w_rw_elem;
  assign w_step      = w_run && w_addr_done;
  assign w_elem_next = (r_elem == EL_M5) ? EL_M0 : elem_t'(r_elem + 3'd1);
  assign w_test_last = w_step && w_addr_last && (r_elem == EL_M5) && (r_bg == BG_LAST);
  assign w_exp       = el_flag(EL_RD_INV, r_elem) ? ~w_pat : w_pat;
  assign w_wdata     = el_flag(EL_WR_INV, r_elem) ? ~w_pat : w_pat;
  assign w_rd_diff   = r_exp ^ mem_rdata;
  assign w_mismatch  = w_active && r_cmp_valid && (w_rd_diff != '0);
  assign w_to_done   = (w_state_next == ST_DONE) && (r_state != ST_DONE);

  march_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .clk         (clk),
    .rst         (rst),
    .i_clear     (w_accept),
    .i_step      (w_step),
    .i_down      (el_flag(EL_DOWN, r_elem)),
    .i_next_down (el_flag(EL_DOWN, w_elem_next)),
    .o_addr      (w_addr),
    .o_last      (w_addr_last)
  );

  assign mem_cs        = w_run;
  assign mem_we        = w_run && !w_op_rd;
  assign mem_addr      = w_run ? w_addr : '0;
  assign mem_wdata     = (w_run && !w_op_rd) ? w_wdata : '0;
  assign bist_busy     = w_active;
  assign done          = r_done;
  assign pass          = r_done && (r_fail_cnt == '0);
  assign fail_cnt      = r_fail_cnt;
  assign fail_valid    = r_fail_valid;
  assign fail_addr     = r_fail_addr;
  assign fail_elem     = r_fail_elem;
  assign fail_bg       = r_fail_bg;
  assign fail_syndrome = r_fail_syn;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (start && !abort) w_state_next = ST_RUN;
      ST_RUN: begin
        if (abort)                            w_state_next = ST_IDLE;
        else if (w_mismatch && r_stop_on_fail) w_state_next = ST_DONE;
        else if (w_test_last)                 w_state_next = ST_DRAIN;
      end
      ST_DRAIN: w_state_next = abort ? ST_IDLE : ST_DONE;
      ST_DONE: begin
        if (abort)      w_state_next = ST_IDLE;
        else if (start) w_state_next = ST_RUN;
      end
      default:  w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_elem         <= EL_M0;
      r_phase        <= 1'b0;
      r_bg           <= '0;
      r_stop_on_fail <= 1'b0;
      r_done         <= 1'b0;
      r_fail_cnt     <= '0;
      r_fail_valid   <= 1'b0;
      r_fail_addr    <= '0;
      r_fail_elem    <= EL_M0;
      r_fail_bg      <= '0;
      r_fail_syn     <= '0;
      r_cmp_valid    <= 1'b0;
      r_exp          <= '0;
      r_cmp_addr     <= '0;
      r_cmp_elem     <= EL_M0;
      r_cmp_bg       <= '0;
    end else begin
      if (w_accept) begin
        r_elem         <= EL_M0;
        r_phase        <= 1'b0;
        r_bg           <= '0;
        r_stop_on_fail <= stop_on_fail;
        r_done         <= 1'b0;
        r_fail_cnt     <= '0;
        r_fail_valid   <= 1'b0;
        r_fail_addr    <= '0;
        r_fail_elem    <= EL_M0;
        r_fail_bg      <= '0;
        r_fail_syn     <= '0;
      end else begin
        if (w_run) begin
          if (!w_addr_done) begin
            r_phase <= 1'b1;
          end else begin
            r_phase <= 1'b0;
            if (w_addr_last) begin
              r_elem <= w_elem_next;
              if (r_elem == EL_M5) r_bg <= r_bg + 1'b1;
            end
          end
        end
        if (w_mismatch) begin
          if (r_fail_cnt != CNT_MAX) r_fail_cnt <= r_fail_cnt + 1'b1;
          if (!r_fail_valid) begin
            r_fail_valid <= 1'b1;
            r_fail_addr  <= r_cmp_addr;
            r_fail_elem  <= r_cmp_elem;
            r_fail_bg    <= r_cmp_bg;
            r_fail_syn   <= w_rd_diff;
          end
        end
        // abort clears done; a completed or stopped test sets it
        if (w_state_next == ST_IDLE) r_done <= 1'b0;
        else if (w_to_done)          r_done <= 1'b1;
      end
      r_cmp_valid <= w_run && w_op_rd;
      r_exp       <= w_exp;
      r_cmp_addr  <= w_addr;
      r_cmp_elem  <= r_elem;
      r_cmp_bg    <= r_bg;
    end
  end

endmodule

// File: tb/tb_march_bist_engine.sv
// Bench: two engines (1 and 4 backgrounds) on behavioural RAMs with
// injectable stuck-at and coupling faults; scoreboard of expected port activity.
module tb_march_bist_engine;

  localparam int AW = 6;
  localparam int DW = 8;
  localparam int N  = 64;
  localparam logic [17:0] MK_ALL = 18'h3FFFF;
  localparam logic [17:0] MK_RD  = 18'h3FF00;
  localparam logic [17:0] MK_CTL = 18'h38000;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic          start_a, abort_a, sof_a, cs_a, we_a, busy_a, done_a, pass_a, fv_a;
  logic [AW-1:0] addr_a, faddr_a;
  logic [DW-1:0] wdata_a, rdata_a, fsyn_a;
  logic [15:0]   cnt_a;
  logic [2:0]    felem_a;
  logic [0:0]    fbg_a;

  logic          start_b, abort_b, sof_b, cs_b, we_b, busy_b, done_b, pass_b, fv_b;
  logic [AW-1:0] addr_b, faddr_b;
  logic [DW-1:0] wdata_b, rdata_b, fsyn_b;
  logic [15:0]   cnt_b;
  logic [2:0]    felem_b;
  logic [2:0]    fbg_b;

  logic          stuck_en;
  logic [DW-1:0] ram_a [N];
  logic [DW-1:0] ram_b [N];

  march_bist_engine #(.ADDR_W(AW), .DATA_W(DW), .NUM_BG(1), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .abort(abort_a), .stop_on_fail(sof_a),
    .mem_cs(cs_a), .mem_we(we_a), .mem_addr(addr_a), .mem_wdata(wdata_a), .mem_rdata(rdata_a),
    .bist_busy(busy_a), .done(done_a), .pass(pass_a), .fail_cnt(cnt_a), .fail_valid(fv_a),
    .fail_addr(faddr_a), .fail_elem(felem_a), .fail_bg(fbg_a), .fail_syndrome(fsyn_a)
  );

  march_bist_engine #(.ADDR_W(AW), .DATA_W(DW), .NUM_BG(4), .CNT_W(16)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .abort(abort_b), .stop_on_fail(sof_b),
    .mem_cs(cs_b), .mem_we(we_b), .mem_addr(addr_b), .mem_wdata(wdata_b), .mem_rdata(rdata_b),
    .bist_busy(busy_b), .done(done_b), .pass(pass_b), .fail_cnt(cnt_b), .fail_valid(fv_b),
    .fail_addr(faddr_b), .fail_elem(felem_b), .fail_bg(fbg_b), .fail_syndrome(fsyn_b)
  );

  // RAM A: bit 3 of address 0x2A stuck at 1 when stuck_en
  always @(posedge clk) begin
    if (cs_a) begin
      if (we_a) ram_a[addr_a] <= wdata_a;
      else      rdata_a <= ram_a[addr_a] | ((stuck_en && addr_a == 6'h2A) ? 8'h08 : 8'h00);
    end
  end

  // RAM B: a write to address 5 flips bit 0 of address 6
  always @(posedge clk) begin
    if (cs_b) begin
      if (we_b) begin
        ram_b[addr_b] <= wdata_b;
        if (addr_b == 6'd5) ram_b[6][0] <= ~ram_b[6][0];
      end else begin
        rdata_b <= ram_b[addr_b];
      end
    end
  end

  typedef struct {
    int          cyc;
    logic [17:0] val;
    logic [17:0] mask;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int total = 0;
  int bad   = 0;

  // {busy, done, cs, we, addr[5:0], wdata[7:0]}
  function automatic logic [17:0] pk(input int busy, input int dn, input int cs,
                                     input int we, input int a, input int d);
    return {busy[0], dn[0], cs[0], we[0], a[5:0], d[7:0]};
  endfunction

  function automatic void expect_at(input int cyc, input logic [17:0] val,
                                    input logic [17:0] mask, input string name);
    exp_t e;
    e.cyc = cyc; e.val = val; e.mask = mask; e.name = name;
    exp_q.push_back(e);
  endfunction

  // Cycle 0 = first RUN cycle (busy first high); scoreboard popped per cycle.
  task automatic run_a(input logic sof, input int abort_at, input int pulse_at,
                       input int max_cyc, output int done_cyc);
    exp_t e;
    logic [17:0] obs;
    done_cyc = -1;
    @(negedge clk);
    start_a = 1'b1;
    sof_a   = sof;
    @(negedge clk);
    start_a = 1'b0;
    for (int cyc = 0; cyc < max_cyc; cyc++) begin
      obs = {busy_a, done_a, cs_a, we_a, addr_a, wdata_a};
      while (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        e = exp_q.pop_front();
        total++;
        if ((obs & e.mask) !== (e.val & e.mask)) begin
          bad++;
          $display("FAIL %s cyc=%0d got=%h want=%h mask=%h", e.name, cyc, obs, e.val, e.mask);
        end
      end
      if (done_a && done_cyc < 0) done_cyc = cyc;
      if (exp_q.size() == 0 && (done_cyc >= 0 || (abort_at >= 0 && cyc > abort_at))) break;
      abort_a = (cyc == abort_at);
      start_a = (cyc == pulse_at);
      @(negedge clk);
    end
    abort_a = 1'b0;
    start_a = 1'b0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      bad++;
      $display("FAIL %s not reached got=none want_cyc=%0d", e.name, e.cyc);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({busy_a, done_a, pass_a, cs_a, we_a} !== 5'b0) begin
      bad++; $display("FAIL reset_ctl got=%b want=00000", {busy_a, done_a, pass_a, cs_a, we_a});
    end
    total++;
    if ({addr_a, wdata_a} !== 14'd0) begin
      bad++; $display("FAIL reset_port got=%h want=0", {addr_a, wdata_a});
    end
    total++;
    if ({cnt_a, fv_a, faddr_a, felem_a, fbg_a, fsyn_a} !== 35'd0) begin
      bad++; $display("FAIL reset_fail got=%h want=0", {cnt_a, fv_a, faddr_a, felem_a, fbg_a, fsyn_a});
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_clean();
    int dc;
    stuck_en = 1'b0;
    expect_at(0,   pk(1,0,1,1,0,8'h00),  MK_ALL, "m0_w0");
    expect_at(1,   pk(1,0,1,1,1,8'h00),  MK_ALL, "m0_w1");
    expect_at(64,  pk(1,0,1,0,0,0),      MK_RD,  "m1_r0");
    expect_at(65,  pk(1,0,1,1,0,8'hFF),  MK_ALL, "m1_w0");
    expect_at(192, pk(1,0,1,0,0,0),      MK_RD,  "m2_r0");
    expect_at(193, pk(1,0,1,1,0,8'h00),  MK_ALL, "m2_w0");
    expect_at(320, pk(1,0,1,0,63,0),     MK_RD,  "m3_r63");
    expect_at(321, pk(1,0,1,1,63,8'hFF), MK_ALL, "m3_w63");
    expect_at(322, pk(1,0,1,0,62,0),     MK_RD,  "m3_r62");
    expect_at(448, pk(1,0,1,0,63,0),     MK_RD,  "m4_r63");
    expect_at(449, pk(1,0,1,1,63,8'h00), MK_ALL, "m4_w63");
    expect_at(576, pk(1,0,1,0,63,0),     MK_RD,  "m5_r63");
    expect_at(577, pk(1,0,1,0,62,0),     MK_RD,  "m5_r62");
    expect_at(639, pk(1,0,1,0,0,0),      MK_RD,  "m5_r0");
    expect_at(640, pk(1,0,0,0,0,0),      MK_CTL, "drain");
    expect_at(641, pk(0,1,0,0,0,0),      MK_CTL, "done");
    run_a(1'b0, -1, -1, 800, dc);
    total++;
    if (dc !== 641) begin bad++; $display("FAIL clean_done_cyc got=%0d want=641", dc); end
    total++;
    if ({pass_a, fv_a, cnt_a} !== {1'b1, 1'b0, 16'd0}) begin
      bad++; $display("FAIL clean_result got pass=%b fv=%b cnt=%0d want pass=1 fv=0 cnt=0", pass_a, fv_a, cnt_a);
    end
  endtask

  task automatic test_stuck();
    int dc;
    stuck_en = 1'b1;
    run_a(1'b0, -1, -1, 800, dc);
    total++;
    if (dc !== 641) begin bad++; $display("FAIL stuck_done_cyc got=%0d want=641", dc); end
    total++;
    if ({fv_a, faddr_a, felem_a, fbg_a} !== {1'b1, 6'h2A, 3'd1, 1'b0}) begin
      bad++; $display("FAIL stuck_record got fv=%b addr=%h elem=%0d bg=%0d want 1 2a 1 0", fv_a, faddr_a, felem_a, fbg_a);
    end
    total++;
    if (fsyn_a !== 8'h08) begin bad++; $display("FAIL stuck_syndrome got=%h want=08", fsyn_a); end
    total++;
    if (cnt_a !== 16'd3) begin bad++; $display("FAIL stuck_cnt got=%0d want=3", cnt_a); end
    total++;
    if (pass_a !== 1'b0) begin bad++; $display("FAIL stuck_pass got=%b want=0", pass_a); end
  endtask

  task automatic test_stop_on_fail();
    int dc;
    stuck_en = 1'b1;
    expect_at(149, pk(1,0,1,1,8'h2A,8'hFF), MK_ALL, "sof_last_access");
    for (int c = 150; c < 154; c++) expect_at(c, pk(0,1,0,0,0,0), MK_CTL, "sof_quiet");
    run_a(1'b1, -1, -1, 800, dc);
    total++;
    if (dc !== 150) begin bad++; $display("FAIL sof_done_cyc got=%0d want=150", dc); end
    total++;
    if ({cnt_a, pass_a, faddr_a, felem_a} !== {16'd1, 1'b0, 6'h2A, 3'd1}) begin
      bad++; $display("FAIL sof_result got cnt=%0d pass=%b addr=%h elem=%0d want 1 0 2a 1", cnt_a, pass_a, faddr_a, felem_a);
    end
  endtask

  task automatic test_abort();
    int dc;
    stuck_en = 1'b0;
    expect_at(100, pk(1,0,1,0,0,0), MK_CTL, "abort_pre");
    expect_at(101, pk(0,0,0,0,0,0), MK_CTL, "abort_idle");
    expect_at(102, pk(0,0,0,0,0,0), MK_CTL, "abort_idle2");
    run_a(1'b0, 100, -1, 300, dc);
    total++;
    if (dc !== -1) begin bad++; $display("FAIL abort_done got done_cyc=%0d want=-1", dc); end
    expect_at(641, pk(0,1,0,0,0,0), MK_CTL, "rerun_done");
    run_a(1'b0, -1, -1, 800, dc);
    total++;
    if ({dc, pass_a} !== {32'd641, 1'b1}) begin
      bad++; $display("FAIL rerun got done_cyc=%0d pass=%b want 641 1", dc, pass_a);
    end
  endtask

  task automatic test_backgrounds();
    logic [7:0] pq[$];
    logic [7:0] want;
    int dc;
    dc = -1;
    pq.push_back(8'h00); pq.push_back(8'hAA); pq.push_back(8'hCC); pq.push_back(8'hF0);
    @(negedge clk);
    start_b = 1'b1;
    sof_b   = 1'b0;
    @(negedge clk);
    start_b = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc % 640 == 0 && pq.size() > 0) begin
        want = pq.pop_front();
        total++;
        if ({cs_b, we_b, addr_b, wdata_b} !== {1'b1, 1'b1, 6'd0, want}) begin
          bad++; $display("FAIL bg_write cyc=%0d got cs=%b we=%b addr=%0d wdata=%h want 1 1 0 %h", cyc, cs_b, we_b, addr_b, wdata_b, want);
        end
      end
      if (done_b) begin dc = cyc; break; end
      @(negedge clk);
    end
    total++;
    if (dc !== 2561 || pq.size() != 0) begin
      bad++; $display("FAIL bg_done_cyc got=%0d left=%0d want=2561 left=0", dc, pq.size());
    end
    total++;
    if ({fv_b, faddr_b, felem_b, fbg_b, fsyn_b} !== {1'b1, 6'd6, 3'd1, 3'd0, 8'h01}) begin
      bad++; $display("FAIL bg_record got fv=%b addr=%0d elem=%0d bg=%0d syn=%h want 1 6 1 0 01", fv_b, faddr_b, felem_b, fbg_b, fsyn_b);
    end
    total++;
    if ({pass_b, (cnt_b != 16'd0)} !== 2'b01) begin
      bad++; $display("FAIL bg_result got pass=%b cnt=%0d want pass=0 cnt>0", pass_b, cnt_b);
    end
  endtask

  task automatic test_reset_mid_run();
    int dc;
    stuck_en = 1'b1;
    @(negedge clk);
    start_a = 1'b1;
    sof_a   = 1'b0;
    @(negedge clk);
    start_a = 1'b0;
    repeat (200) @(negedge clk);
    total++;
    if ({fv_a, cnt_a, busy_a} !== {1'b1, 16'd1, 1'b1}) begin
      bad++; $display("FAIL prereset got fv=%b cnt=%0d busy=%b want 1 1 1", fv_a, cnt_a, busy_a);
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if ({busy_a, cs_a, done_a, pass_a} !== 4'b0) begin
      bad++; $display("FAIL async_rst_ctl got=%b want=0000", {busy_a, cs_a, done_a, pass_a});
    end
    total++;
    if ({cnt_a, fv_a, faddr_a, felem_a, fsyn_a} !== 34'd0) begin
      bad++; $display("FAIL async_rst_fail got=%h want=0", {cnt_a, fv_a, faddr_a, felem_a, fsyn_a});
    end
    @(negedge clk);
    @(negedge clk);
    rst      = 1'b0;
    stuck_en = 1'b0;
    expect_at(31,  pk(1,0,1,1,31,8'h00), MK_ALL, "pulse_no_restart");
    expect_at(641, pk(0,1,0,0,0,0),      MK_CTL, "pulse_done");
    run_a(1'b0, -1, 30, 800, dc);
    total++;
    if ({dc, pass_a} !== {32'd641, 1'b1}) begin
      bad++; $display("FAIL pulse_run got done_cyc=%0d pass=%b want 641 1", dc, pass_a);
    end
  endtask

  initial begin
    rst = 1'b1;
    start_a = 1'b0; abort_a = 1'b0; sof_a = 1'b0;
    start_b = 1'b0; abort_b = 1'b0; sof_b = 1'b0;
    stuck_en = 1'b0;
    test_reset();
    test_clean();
    test_stuck();
    test_stop_on_fail();
    test_abort();
    test_backgrounds();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
